// File: rtl/ad7606_emulator.sv
// AD7606 responder model: convert/busy/read parallel interface with a deterministic data pattern.
// Each served word is {channel[2:0], snapshot[12:0]}, where snapshot is the
// conversion sequence number.
`timescale 1ns/1ps
module ad7606_emulator #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned TCONV_BASE = 800,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        convst_i,
    input  logic        cs_i,
    input  logic        rd_i,
    input  logic [2:0]  os_i,
    output logic        busy_o,
    output logic [15:0] db_o,
    output logic        db_oe_o,
    output logic        frstdata_o
);

    typedef enum logic [1:0] {StIdle, StConvert, StReady} state_t;

    localparam logic [CNT_W-1:0] TCONV   = CNT_W'(TCONV_BASE);
    localparam logic [3:0]       LAST_CH = 4'(CHANNELS - 1);

    // [0] first sync flop, [1] synchronized level, [2] previous level for edge detect
    logic [2:0] convst_sync;
    logic [2:0] cs_sync;
    logic [2:0] rd_sync;

    state_t           state;
    logic [CNT_W-1:0] conv_cnt;
    logic [12:0]      sample_cnt;
    logic [12:0]      snapshot;
    logic [3:0]       ch_ptr;

    logic             convst_rise;
    logic             rd_fall;
    logic             rd_rise;
    logic             cs_active;
    logic [2:0]       os_lat;
    logic [CNT_W-1:0] conv_load;

    // Synchronize the asynchronous pins; reset parks them at their inactive levels
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            convst_sync <= 3'b000;
            cs_sync     <= 3'b111;
            rd_sync     <= 3'b111;
        end else begin
            convst_sync <= {convst_sync[1:0], convst_i};
            cs_sync     <= {cs_sync[1:0], cs_i};
            rd_sync     <= {rd_sync[1:0], rd_i};
        end
    end

    // Edge decodes and conversion length; os=7 is an invalid code and runs as os=0
    always_comb begin
        convst_rise = convst_sync[1] & ~convst_sync[2];
        rd_fall     = ~rd_sync[1] & rd_sync[2];
        rd_rise     = rd_sync[1] & ~rd_sync[2];
        cs_active   = ~cs_sync[1];
        os_lat      = (os_i == 3'd7) ? 3'd0 : os_i;
        conv_load   = TCONV << os_lat;
        db_oe_o     = ~cs_sync[1] & ~rd_sync[1];
    end

    // Conversion/readout FSM with registered outputs; convst has priority over rd
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= StIdle;
            conv_cnt   <= '0;
            sample_cnt <= '0;
            snapshot   <= '0;
            ch_ptr     <= '0;
            busy_o     <= 1'b0;
            db_o       <= '0;
            frstdata_o <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (convst_rise) begin
                        state      <= StConvert;
                        conv_cnt   <= conv_load;
                        db_o       <= '0;
                        frstdata_o <= 1'b0;
                    end else if (cs_active && rd_fall) begin
                        db_o       <= '0;
                        frstdata_o <= 1'b0;
                    end
                end
                StConvert: begin
                    // busy rises one edge after entry and falls once the count is spent
                    if (conv_cnt == '0) begin
                        busy_o     <= 1'b0;
                        snapshot   <= sample_cnt;
                        sample_cnt <= sample_cnt + 13'd1;
                        ch_ptr     <= '0;
                        state      <= StReady;
                    end else begin
                        busy_o   <= 1'b1;
                        conv_cnt <= conv_cnt - 1'b1;
                    end
                end
                StReady: begin
                    if (convst_rise) begin
                        // Abandon the remaining words and restart
                        state      <= StConvert;
                        conv_cnt   <= conv_load;
                        db_o       <= '0;
                        frstdata_o <= 1'b0;
                    end else if (cs_active && rd_fall) begin
                        db_o       <= {ch_ptr[2:0], snapshot};
                        frstdata_o <= (ch_ptr == 4'd0);
                    end else if (cs_active && rd_rise) begin
                        frstdata_o <= 1'b0;
                        ch_ptr     <= ch_ptr + 4'd1;
                        if (ch_ptr == LAST_CH) begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ad7606_emulator.sv
// Self-checking bench for ad7606_emulator against a transaction-level model.
`timescale 1ns/1ps
module tb_ad7606_emulator;

    localparam int CHANNELS   = 8;
    localparam int TCONV_BASE = 800;
    localparam int LIMIT      = 52000;

    logic        clk;
    logic        reset;
    logic        convst;
    logic        cs;
    logic        rd;
    logic [2:0]  os_pin;
    logic        busy;
    logic [15:0] db;
    logic        db_oe;
    logic        frst;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_sample;
    logic [12:0] m_snap;
    int          m_ch;
    bit          m_ready;

    ad7606_emulator #(
        .CHANNELS  (CHANNELS),
        .TCONV_BASE(TCONV_BASE),
        .CNT_W     (16)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .convst_i  (convst),
        .cs_i      (cs),
        .rd_i      (rd),
        .os_i      (os_pin),
        .busy_o    (busy),
        .db_o      (db),
        .db_oe_o   (db_oe),
        .frstdata_o(frst)
    );

    initial clk = 1'b0;
    always #2.5 clk = ~clk;

    function automatic int model_cycles(input logic [2:0] os);
        int sh;
        sh = (os == 3'd7) ? 0 : int'(os);
        return TCONV_BASE << sh;
    endfunction

    task automatic model_reset();
        m_sample = 0;
        m_snap   = '0;
        m_ch     = 0;
        m_ready  = 0;
    endtask

    task automatic model_conv();
        m_snap   = 13'(m_sample);
        m_sample = (m_sample + 1) % 8192;
        m_ch     = 0;
        m_ready  = 1;
    endtask

    task automatic model_read(output logic [15:0] w, output logic f);
        if (m_ready) begin
            w = {3'(m_ch), m_snap};
            f = (m_ch == 0);
            m_ch++;
            if (m_ch == CHANNELS) m_ready = 0;
        end else begin
            w = 16'h0000;
            f = 1'b0;
        end
    endtask

    // All stimulus tasks start and end 1 ns after a rising edge
    task automatic pulse_convst(input logic [2:0] os, output logic early, output logic on);
        os_pin = os;
        convst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        early = busy;
        @(posedge clk);
        #1;
        on = busy;
        convst = 1'b0;
    endtask

    // Counts cycles of busy high (the first was seen by pulse_convst); optional disturbance
    task automatic wait_busy(input bit disturb, output int n, output logic [15:0] db_seen,
                             output logic oe_seen);
        n = 1;
        db_seen = 16'hxxxx;
        oe_seen = 1'bx;
        while (n <= LIMIT) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1) break;
            n++;
            if (disturb) begin
                if (n == 100) convst = 1'b1;
                if (n == 110) convst = 1'b0;
                if (n >= 200 && n < 260) rd = ((n / 3) % 2 == 0) ? 1'b0 : 1'b1;
                if (n == 260) rd = 1'b1;
                if (n == 300) cs = 1'b0;
                if (n == 303) rd = 1'b0;
                if (n == 310) begin
                    db_seen = db;
                    oe_seen = db_oe;
                end
                if (n == 312) rd = 1'b1;
                if (n == 318) cs = 1'b1;
            end
        end
    endtask

    task automatic set_cs(input logic v);
        cs = v;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // One 15 ns low / 15 ns high read strobe
    task automatic do_read(output logic [15:0] d, output logic f, output logic oe,
                           output logic f_after);
        rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        oe = db_oe;
        rd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        d = db;
        f = frst;
        @(posedge clk);
        #1;
        f_after = frst;
    endtask

    task automatic test_reset();
        convst = 1'b0;
        cs     = 1'b1;
        rd     = 1'b1;
        os_pin = 3'd0;
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (db !== 16'h0000) begin
            miscompares++; $display("FAIL reset_db: got %h want 0000", db);
        end
        vectors++;
        if (db_oe !== 1'b0) begin
            miscompares++; $display("FAIL reset_oe: got %b want 0", db_oe);
        end
        vectors++;
        if (frst !== 1'b0) begin
            miscompares++; $display("FAIL reset_frst: got %b want 0", frst);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // Starts a conversion and checks its latency and duration against the model
    task automatic conv_checked(input logic [2:0] os, input bit disturb, input string tag);
        logic early, on, oe_seen;
        logic [15:0] db_seen;
        int n, want;
        want = model_cycles(os);
        pulse_convst(os, early, on);
        vectors++;
        if (early !== 1'b0) begin
            miscompares++; $display("FAIL %s_busy_early: got %b want 0", tag, early);
        end
        vectors++;
        if (on !== 1'b1) begin
            miscompares++; $display("FAIL %s_busy_rise: got %b want 1", tag, on);
        end
        wait_busy(disturb, n, db_seen, oe_seen);
        vectors++;
        if (n != want) begin
            miscompares++; $display("FAIL %s_busy_len: got %0d want %0d", tag, n, want);
        end
        if (disturb) begin
            vectors++;
            if (db_seen !== 16'h0000) begin
                miscompares++; $display("FAIL %s_db_in_conv: got %h want 0000", tag, db_seen);
            end
            vectors++;
            if (oe_seen !== 1'b1) begin
                miscompares++; $display("FAIL %s_oe_in_conv: got %b want 1", tag, oe_seen);
            end
        end
        model_conv();
    endtask

    task automatic reads_checked(input int k, input string tag);
        logic [15:0] d, wd;
        logic f, wf, oe, fa;
        for (int i = 0; i < k; i++) begin
            model_read(wd, wf);
            do_read(d, f, oe, fa);
            vectors++;
            if (d !== wd) begin
                miscompares++; $display("FAIL %s_db[%0d]: got %h want %h", tag, i, d, wd);
            end
            vectors++;
            if (f !== wf) begin
                miscompares++; $display("FAIL %s_frst[%0d]: got %b want %b", tag, i, f, wf);
            end
            vectors++;
            if (oe !== 1'b1) begin
                miscompares++; $display("FAIL %s_oe[%0d]: got %b want 1", tag, i, oe);
            end
            vectors++;
            if (fa !== 1'b0) begin
                miscompares++; $display("FAIL %s_frst_clr[%0d]: got %b want 0", tag, i, fa);
            end
        end
    endtask

    task automatic test_conv_basic();
        conv_checked(3'd0, 1'b0, "conv_os0");
    endtask

    task automatic test_readout();
        set_cs(1'b0);
        reads_checked(CHANNELS + 1, "readout");
        set_cs(1'b1);
    endtask

    task automatic test_os();
        conv_checked(3'd3, 1'b0, "conv_os3");
        conv_checked(3'd7, 1'b0, "conv_os7");
    endtask

    task automatic test_back_to_back();
        conv_checked(3'd0, 1'b0, "b2b_first");
        set_cs(1'b0);
        reads_checked(3, "b2b_partial");
        conv_checked(3'd0, 1'b0, "b2b_restart");
        reads_checked(2, "b2b_after");
        set_cs(1'b1);
    endtask

    task automatic test_ignore();
        conv_checked(3'd0, 1'b1, "ignore");
        // rd strobes with cs high in READY must not advance the channel
        for (int i = 0; i < 2; i++) begin
            rd = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            vectors++;
            if (db_oe !== 1'b0) begin
                miscompares++; $display("FAIL ignore_oe_cs_high: got %b want 0", db_oe);
            end
            rd = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            vectors++;
            if (db !== 16'h0000) begin
                miscompares++; $display("FAIL ignore_db_cs_high: got %h want 0000", db);
            end
        end
        set_cs(1'b0);
        reads_checked(2, "ignore_read");
        set_cs(1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            conv_checked(3'($urandom_range(0, 2)), 1'b0, "rand_conv");
            set_cs(1'b0);
            reads_checked(int'($urandom_range(0, CHANNELS + 1)), "rand_read");
            set_cs(1'b1);
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        logic early, on;
        pulse_convst(3'd0, early, on);
        repeat (400) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy);
        end
        vectors++;
        if (db !== 16'h0000) begin
            miscompares++; $display("FAIL rstmid_db: got %h want 0000", db);
        end
        reset = 1'b0;
        model_reset();
        repeat (900) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_stays_idle: got %b want 0", busy);
        end
        // Reset during readout while a word is on the bus
        conv_checked(3'd0, 1'b0, "rstrd_conv");
        set_cs(1'b0);
        reads_checked(1, "rstrd_first");
        rd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (db !== 16'h2000) begin
            miscompares++; $display("FAIL rstrd_word: got %h want 2000", db);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (db !== 16'h0000) begin
            miscompares++; $display("FAIL rstrd_db: got %h want 0000", db);
        end
        vectors++;
        if (db_oe !== 1'b0) begin
            miscompares++; $display("FAIL rstrd_oe: got %b want 0", db_oe);
        end
        rd    = 1'b1;
        cs    = 1'b1;
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        conv_checked(3'd0, 1'b0, "post_reset");
        set_cs(1'b0);
        reads_checked(2, "post_reset_read");
        set_cs(1'b1);
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        test_reset();
        test_conv_basic();
        test_readout();
        test_os();
        test_back_to_back();
        test_ignore();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
